// File: rtl/seq_div_ctrl.sv
// Sequential unsigned restoring divider controller: one quotient bit per cycle,
// driving an external shared combinational subtractor through sub_a/sub_b.
module seq_div_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_diff,
  input  logic             sub_cout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_r;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_d;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;

  logic [WIDTH-1:0]   w_sub_a;
  logic [WIDTH-1:0]   w_sub_b;
  logic               w_accept;
  logic [WIDTH-1:0]   w_r_nxt;
  logic [WIDTH-1:0]   w_q_nxt;

  always_comb begin
    w_next_state = r_state;
    w_sub_a      = '0;
    w_sub_b      = '0;
    w_accept     = 1'b0;
    w_r_nxt      = r_r;
    w_q_nxt      = r_q;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (divisor != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // A set R MSB means the shifted trial is >= 2^WIDTH, so it always exceeds D.
        w_sub_a  = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
        w_sub_b  = r_d;
        w_accept = sub_cout | r_r[WIDTH-1];
        w_r_nxt  = w_accept ? sub_diff : w_sub_a;
        w_q_nxt  = {r_q[WIDTH-2:0], w_accept};
        if (r_cnt == '0) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_r        <= '0;
      r_q        <= '0;
      r_d        <= '0;
      r_cnt      <= '0;
      r_div_zero <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_q        <= dividend;
              r_d        <= divisor;
              r_r        <= '0;
              r_cnt      <= CNT_W'(WIDTH - 1);
              r_div_zero <= 1'b0;
            end else begin
              r_quot     <= '1;
              r_rem      <= dividend;
              r_div_zero <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_r <= w_r_nxt;
          r_q <= w_q_nxt;
          if (r_cnt == '0) begin
            r_quot <= w_q_nxt;
            r_rem  <= w_r_nxt;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign div_zero  = r_div_zero;
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign sub_a     = w_sub_a;
  assign sub_b     = w_sub_b;

endmodule
